// File: rtl/spi_frame_slave.sv
// SPI target for the SD-card controller: oversampled pins, all four SPI modes, CS framing,
// command start-bit hunting and start-token framed receive/transmit data phases.
module spi_frame_slave #(
    parameter int         CMD_BYTES   = 6,
    parameter int         DEPTH       = 64,
    parameter bit         CPOL        = 1'b0,
    parameter bit         CPHA        = 1'b0,
    parameter logic [7:0] START_TOKEN = 8'hFE,
    parameter logic [7:0] IDLE_FILL   = 8'hFF,
    parameter int         ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sclk,
    input  logic                   mosi,
    input  logic                   cs_n,
    output logic                   miso,
    output logic [CMD_BYTES*8-1:0] cmd,
    output logic                   cmd_valid,
    input  logic                   start,
    input  logic                   op,
    input  logic [ADDR_W-1:0]      size,
    output logic [ADDR_W-1:0]      buf_addr,
    output logic [7:0]             buf_wdata,
    output logic                   buf_we,
    input  logic [7:0]             buf_rdata,
    output logic                   busy,
    output logic                   done,
    output logic                   abort,
    output logic [2:0]             state_dbg
);

    localparam int CMD_W = CMD_BYTES * 8;
    localparam int CNT_W = (ADDR_W + 1 > $clog2(CMD_BYTES) + 1) ? ADDR_W + 1 : $clog2(CMD_BYTES) + 1;
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_BYTES - 1);
    localparam logic SAMPLE_RISE = (CPOL == CPHA);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_WAIT = 3'd2,
        ST_RX   = 3'd3,
        ST_TX   = 3'd4
    } state_t;

    state_t            state;
    logic [2:0]        sclk_sy;
    logic [1:0]        cs_sy;
    logic [1:0]        mosi_sy;
    logic [2:0]        bit_cnt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [6:0]        rx_sr;
    logic [7:0]        tx_sr;
    logic [CMD_W-1:0]  cmd_sr;
    logic [ADDR_W-1:0] size_r;
    logic              tok;

    logic              cs_s, mosi_s, sclk_rise, sclk_fall, sample_stb, shift_stb, hunting;
    logic [7:0]        rx_byte;
    logic [CMD_W-1:0]  cmd_next;
    logic [CNT_W-1:0]  size_ext, size_end;

    assign cs_s       = cs_sy[1];
    assign mosi_s     = mosi_sy[1];
    assign sclk_rise  = sclk_sy[1] & ~sclk_sy[2];
    assign sclk_fall  = ~sclk_sy[1] & sclk_sy[2];
    assign sample_stb = SAMPLE_RISE ? sclk_rise : sclk_fall;
    assign shift_stb  = SAMPLE_RISE ? sclk_fall : sclk_rise;
    assign hunting    = (state == ST_CMD) && (byte_cnt == '0) && (bit_cnt == 3'd0);
    assign rx_byte    = {rx_sr, mosi_s};
    assign cmd_next   = (cmd_sr << 8) | CMD_W'(rx_byte);
    assign size_ext   = CNT_W'(size_r);
    assign size_end   = size_ext + 1'b1;

    assign miso      = tx_sr[7];
    assign busy      = (state == ST_RX) || (state == ST_TX);
    assign state_dbg = state;

    // start is honoured only in ST_WAIT; cmd_valid, buf_we, done and abort are
    // single-cycle strobes with no backpressure from the controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            sclk_sy   <= {3{CPOL}};
            cs_sy     <= 2'b11;
            mosi_sy   <= 2'b00;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            rx_sr     <= '0;
            tx_sr     <= 8'hFF;
            cmd_sr    <= '0;
            size_r    <= '0;
            tok       <= 1'b0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            buf_addr  <= '0;
            buf_wdata <= '0;
            buf_we    <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            sclk_sy   <= {sclk_sy[1:0], sclk};
            cs_sy     <= {cs_sy[0], cs_n};
            mosi_sy   <= {mosi_sy[0], mosi};
            cmd_valid <= 1'b0;
            buf_we    <= 1'b0;
            done      <= 1'b0;
            abort     <= 1'b0;

            if (cs_s) begin
                if (state == ST_RX || state == ST_TX) abort <= 1'b1;
                state    <= ST_IDLE;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                tok      <= 1'b0;
                tx_sr    <= IDLE_FILL;
            end else if (state == ST_IDLE) begin
                // Loading here presents bit 7 before the first leading edge in CPHA=0.
                state    <= ST_CMD;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                tok      <= 1'b0;
                tx_sr    <= IDLE_FILL;
            end else begin
                if (state == ST_WAIT && start) begin
                    state    <= op ? ST_TX : ST_RX;
                    size_r   <= size;
                    byte_cnt <= '0;
                    tok      <= 1'b0;
                    buf_addr <= '0;
                end

                if (sample_stb && !(hunting && mosi_s)) begin
                    rx_sr   <= rx_byte[6:0];
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            ST_CMD: begin
                                cmd_sr <= cmd_next;
                                if (byte_cnt == CMD_LAST) begin
                                    cmd       <= cmd_next;
                                    cmd_valid <= 1'b1;
                                    state     <= ST_WAIT;
                                    byte_cnt  <= '0;
                                end else begin
                                    byte_cnt <= byte_cnt + 1'b1;
                                end
                            end
                            ST_RX: begin
                                if (!tok) begin
                                    if (rx_byte == START_TOKEN) tok <= 1'b1;
                                end else begin
                                    buf_wdata <= rx_byte;
                                    buf_addr  <= byte_cnt[ADDR_W-1:0];
                                    buf_we    <= 1'b1;
                                    if (byte_cnt == size_ext) begin
                                        done     <= 1'b1;
                                        state    <= ST_CMD;
                                        byte_cnt <= '0;
                                        tok      <= 1'b0;
                                    end else begin
                                        byte_cnt <= byte_cnt + 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end

                // bit_cnt==0 on a shift edge means bit 7 of a fresh byte goes out next.
                if (shift_stb) begin
                    if (bit_cnt == 3'd0) begin
                        if (state == ST_TX && !tok) begin
                            tx_sr <= START_TOKEN;
                            tok   <= 1'b1;
                        end else if (state == ST_TX && byte_cnt != size_end) begin
                            tx_sr    <= buf_rdata;
                            buf_addr <= buf_addr + 1'b1;
                            byte_cnt <= byte_cnt + 1'b1;
                        end else begin
                            tx_sr <= IDLE_FILL;
                        end
                    end else begin
                        tx_sr <= {tx_sr[6:0], 1'b1};
                        if (state == ST_TX && tok && bit_cnt == 3'd7 && byte_cnt == size_end) begin
                            done     <= 1'b1;
                            state    <= ST_CMD;
                            bit_cnt  <= '0;
                            byte_cnt <= '0;
                            tok      <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: one instance per SPI mode, index = {CPOL, CPHA}.
module tb_spi_frame_slave;

    localparam int H = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0] sclk_v  = 4'b1100;
    logic [3:0] mosi_v  = 4'b1111;
    logic [3:0] cs_n_v  = 4'b1111;
    logic [3:0] start_v = 4'b0000;
    logic       op      = 1'b0;
    logic [5:0] size    = '0;

    logic [3:0] miso_v, cmd_valid_v, buf_we_v, busy_v, done_v, abort_v;
    logic [47:0] cmd_a       [4];
    logic [5:0]  buf_addr_a  [4];
    logic [7:0]  buf_wdata_a [4];
    logic [7:0]  buf_rdata_a [4];
    logic [2:0]  state_a     [4];
    logic [7:0]  mem [4][64];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_frame_slave #(
            .CMD_BYTES(6), .DEPTH(64), .CPOL((g / 2) == 1), .CPHA((g % 2) == 1),
            .START_TOKEN(8'hFE), .IDLE_FILL(8'hFF)
        ) u_dut (
            .clk(clk), .rst(rst), .sclk(sclk_v[g]), .mosi(mosi_v[g]), .cs_n(cs_n_v[g]),
            .miso(miso_v[g]), .cmd(cmd_a[g]), .cmd_valid(cmd_valid_v[g]),
            .start(start_v[g]), .op(op), .size(size),
            .buf_addr(buf_addr_a[g]), .buf_wdata(buf_wdata_a[g]), .buf_we(buf_we_v[g]),
            .buf_rdata(buf_rdata_a[g]), .busy(busy_v[g]), .done(done_v[g]),
            .abort(abort_v[g]), .state_dbg(state_a[g])
        );
        assign buf_rdata_a[g] = mem[g][buf_addr_a[g]];
    end

    int tests = 0;
    int failed = 0;
    int cv_cnt[4], done_cnt[4], abort_cnt[4], we_cnt[4];
    logic [13:0] exp_q[$];
    logic [13:0] got_q[$];

    always @(negedge clk) begin
        for (int m = 0; m < 4; m++) begin
            if (cmd_valid_v[m]) cv_cnt[m]    <= cv_cnt[m] + 1;
            if (done_v[m])      done_cnt[m]  <= done_cnt[m] + 1;
            if (abort_v[m])     abort_cnt[m] <= abort_cnt[m] + 1;
            if (buf_we_v[m])    we_cnt[m]    <= we_cnt[m] + 1;
        end
        if (buf_we_v[0]) got_q.push_back({buf_addr_a[0], buf_wdata_a[0]});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_xfer(input int m, input logic [7:0] din, input int nbits,
                            output logic [7:0] dout);
        logic cpol, cpha;
        cpol = (m / 2) == 1;
        cpha = (m % 2) == 1;
        dout = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                mosi_v[m] = din[7-i];
                wait_clk(H);
                dout = {dout[6:0], miso_v[m]};
                sclk_v[m] = ~cpol;
                wait_clk(H);
                sclk_v[m] = cpol;
            end else begin
                sclk_v[m] = ~cpol;
                mosi_v[m] = din[7-i];
                wait_clk(H);
                dout = {dout[6:0], miso_v[m]};
                sclk_v[m] = cpol;
                wait_clk(H);
            end
        end
    endtask

    task automatic send_frame(input int m, input logic [63:0] data, input int n,
                              output logic [63:0] rx);
        logic [7:0] b, r;
        rx = '0;
        for (int k = 0; k < n; k++) begin
            b = data[8*(n-1-k) +: 8];
            spi_xfer(m, b, 8, r);
            rx = {rx[55:0], r};
        end
        wait_clk(4);
    endtask

    task automatic cs_low(input int m);
        cs_n_v[m] = 1'b0;
        wait_clk(H);
    endtask

    task automatic pulse_start(input int m, input logic o, input logic [5:0] s);
        op = o;
        size = s;
        start_v[m] = 1'b1;
        wait_clk(1);
        start_v[m] = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        logic [13:0] e, g;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check(tag, g, e);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    logic [63:0] rx;
    logic [7:0]  r0, r1, r2a, r2b;

    initial begin
        mem[3][0] = 8'hA5;
        mem[3][1] = 8'h3C;

        // Reset values
        wait_clk(4);
        check("rst_miso",     miso_v, 4'hF);
        check("rst_cmd",      cmd_a[0], 48'h0);
        check("rst_strobes",  {cmd_valid_v[0], done_v[0], abort_v[0], buf_we_v[0], busy_v[0]}, 5'b0);
        check("rst_buf_addr", buf_addr_a[0], 6'h0);
        check("rst_wdata",    buf_wdata_a[0], 8'h0);
        check("rst_state",    state_a[0], 3'd0);
        rst = 1'b0;
        wait_clk(4);

        // Mode 0 command with leading idle bytes
        cs_low(0);
        send_frame(0, 64'hFFFF_4000_0000_0095, 8, rx);
        check("m0_cmd_valid_n", cv_cnt[0], 1);
        check("m0_cmd",         cmd_a[0], 48'h4000_0000_0095);
        check("m0_miso_idle",   rx, 64'hFFFF_FFFF_FFFF_FFFF);
        check("m0_state_wait",  state_a[0], 3'd2);

        // Receive four bytes after the start token
        pulse_start(0, 1'b0, 6'd3);
        check("rx_busy",  busy_v[0], 1'b1);
        check("rx_state", state_a[0], 3'd3);
        exp_q.push_back({6'd0, 8'h11});
        exp_q.push_back({6'd1, 8'h22});
        exp_q.push_back({6'd2, 8'h33});
        exp_q.push_back({6'd3, 8'h44});
        send_frame(0, 64'h00FF_FFFE_1122_3344, 7, rx);
        check("rx_we_n",     we_cnt[0], 4);
        check("rx_done_n",   done_cnt[0], 1);
        check("rx_miso",     rx, 64'h00FF_FFFF_FFFF_FFFF);
        check("rx_state",    state_a[0], 3'd1);
        check("rx_busy_low", busy_v[0], 1'b0);
        compare_writes("rx_wr");

        // Command straight after the data phase (hunting)
        send_frame(0, 64'h0000_5100_0002_00FF, 6, rx);
        check("m0_cmd2_n", cv_cnt[0], 2);
        check("m0_cmd2",   cmd_a[0], 48'h5100_0002_00FF);

        // Abort after token + 12 data bits
        pulse_start(0, 1'b0, 6'd3);
        exp_q.push_back({6'd0, 8'hAB});
        send_frame(0, 64'h0000_0000_0000_FEAB, 2, rx);
        spi_xfer(0, 8'hC0, 4, r0);
        wait_clk(H);
        cs_n_v[0] = 1'b1;
        wait_clk(6);
        check("abort_n",      abort_cnt[0], 1);
        check("abort_done_n", done_cnt[0], 1);
        check("abort_we_n",   we_cnt[0], 5);
        check("abort_state",  state_a[0], 3'd0);
        check("abort_busy",   busy_v[0], 1'b0);
        compare_writes("abort_wr");

        // Next frame decodes normally
        cs_low(0);
        send_frame(0, 64'h0000_4000_0000_0095, 6, rx);
        check("post_abort_cmd_n", cv_cnt[0], 3);
        check("post_abort_cmd",   cmd_a[0], 48'h4000_0000_0095);

        // Remaining modes, same command
        for (int m = 1; m < 4; m++) begin
            cs_low(m);
            send_frame(m, 64'h0000_5100_0002_00FF, 6, rx);
            check($sformatf("mode%0d_cmd_n", m), cv_cnt[m], 1);
            check($sformatf("mode%0d_cmd", m),   cmd_a[m], 48'h5100_0002_00FF);
        end

        // Mode 3 transmit of two buffer bytes
        pulse_start(3, 1'b1, 6'd1);
        check("tx_busy", busy_v[3], 1'b1);
        spi_xfer(3, 8'hFF, 8, r0);
        spi_xfer(3, 8'hFF, 8, r1);
        spi_xfer(3, 8'hFF, 7, r2a);
        check("tx_no_early_done", done_cnt[3], 0);
        spi_xfer(3, 8'hFF, 1, r2b);
        check("tx_done_n", done_cnt[3], 1);
        check("tx_byte0",  r0, 8'hFE);
        check("tx_byte1",  r1, 8'hA5);
        check("tx_byte2",  {r2a[6:0], r2b[0]}, 8'h3C);
        check("tx_state",  state_a[3], 3'd1);
        check("tx_busy_low", busy_v[3], 1'b0);
        spi_xfer(3, 8'hFF, 8, r0);
        check("tx_idle_fill", r0, 8'hFF);
        check("tx_no_cmd",    cv_cnt[3], 1);

        // Reset in the middle of a transmit
        send_frame(3, 64'h0000_4000_0000_0095, 6, rx);
        check("m3_cmd2_n", cv_cnt[3], 2);
        pulse_start(3, 1'b1, 6'd1);
        spi_xfer(3, 8'hFF, 8, r0);
        check("tx2_token", r0, 8'hFE);
        spi_xfer(3, 8'hFF, 2, r1);
        check("tx2_bits",      r1, 8'h02);
        check("tx2_busy",      busy_v[3], 1'b1);
        check("tx2_miso_low",  miso_v[3], 1'b0);
        rst = 1'b1;
        wait_clk(1);
        check("mid_rst_miso",     miso_v[3], 1'b1);
        check("mid_rst_cmd",      cmd_a[3], 48'h0);
        check("mid_rst_strobes",  {cmd_valid_v[3], done_v[3], abort_v[3], buf_we_v[3], busy_v[3]}, 5'b0);
        check("mid_rst_buf_addr", buf_addr_a[3], 6'h0);
        check("mid_rst_wdata",    buf_wdata_a[3], 8'h0);
        check("mid_rst_state",    state_a[3], 3'd0);
        rst = 1'b0;
        cs_n_v = 4'hF;
        wait_clk(4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/spi_frame_slave.md
# spi_frame_slave

Parametrised SPI target for the SD-card controller: successor to the fixed byte-oriented slave, adding all four SPI modes, chip-select framing with abort, start-bit hunting on commands, start-token handling on both data directions, and a configurable command length and buffer depth. Sits between the external SPI pins and the controller's byte buffer. Pins are sampled in the single `clk` domain; `sclk` is never used as a clock.

## Interface
- `CMD_BYTES`, 6: command bytes per command frame (≥1).
- `DEPTH`, 64: data buffer bytes; `ADDR_W = $clog2(DEPTH)`.
- `CPOL`, 0: idle level of `sclk`.
- `CPHA`, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `START_TOKEN`, 8'hFE: data start token, both directions.
- `IDLE_FILL`, 8'hFF: byte driven on `miso` when not transmitting data.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `sclk`, `mosi`, `cs_n`  in  1 each  asynchronous SPI pins.
- `miso`  out  1  SPI data out, registered.
- `cmd`  out  CMD_BYTES*8  received command; byte 0 in MSBs.
- `cmd_valid`  out  1  one-cycle pulse when `cmd` updates.
- `start`  in  1  accept data phase (only in WAIT).
- `op`  in  1  0 = receive from host into buffer, 1 = transmit buffer to host.
- `size`  in  ADDR_W  data bytes minus 1.
- `buf_addr`  out  ADDR_W  buffer address.
- `buf_wdata`  out  8  write data.
- `buf_we`  out  1  one-cycle write strobe.
- `buf_rdata`  in  8  combinational read of `buf_addr`.
- `busy`  out  1  high in RX/TX states.
- `done`  out  1  one-cycle pulse at data-phase completion.
- `abort`  out  1  one-cycle pulse when `cs_n` rises during RX/TX.

## Operation
- `sclk`, `mosi`, `cs_n` pass through 2-FF synchronisers; edges detected on the synchronised `sclk` (1 extra register).
- Sample edge = rising if CPOL==CPHA, else falling; shift edge = the other.
- Bits MSB first. Bit counter 0..7; byte counter ADDR_W+1 bits, no wrap (`size` ≤ DEPTH-1).
- States:
  - IDLE: `cs_n` high. `cs_n` low → CMD (bit/byte counters cleared).
  - CMD: hunt: while byte 0 bit 7 pending, sampled 1s are discarded; first 0 starts byte 0. After CMD_BYTES bytes: `cmd` updates, `cmd_valid` pulses, → WAIT.
  - WAIT: `miso` sends IDLE_FILL. `start` latches `op`, `size`, clears byte counter; → RX (op=0) or TX (op=1). `start` outside WAIT ignored.
  - RX: byte-aligned to frame; received bytes ≠ START_TOKEN discarded until START_TOKEN seen. Then each completed byte: `buf_wdata` = byte, `buf_addr` = byte counter, `buf_we` pulse. After byte index `size`: `done` pulse → CMD (hunting).
  - TX: next byte boundary sends START_TOKEN, then `buf_rdata` for addresses 0..size; `buf_addr` presents next index before its byte is loaded. After last byte's 8th shift: `done` pulse → CMD, `miso` back to IDLE_FILL.
- `miso`: driven from transmit shift register MSB, updated on shift edges; CPHA=0 additionally loads bit 7 on `cs_n` falling edge. Byte source chosen when its bit 7 is presented.
- `cs_n` high in any state → IDLE next cycle, partial bytes dropped; `abort` pulses if state was RX or TX. `cs_n` has priority over a same-cycle `sclk` edge.
- `busy` = state ∈ {RX, TX}.

## Timing
- Reset: state IDLE; `miso`=1; `cmd`=0; `cmd_valid`, `done`, `abort`, `buf_we`, `busy`=0; `buf_addr`=0; `buf_wdata`=0; counters 0.
- `sclk` high and low phases must each last ≥3 `clk` cycles.
- Pin-to-action latency: 3 `clk` cycles from `sclk` edge to internal edge strobe.
- `cmd_valid`, `buf_we` assert the cycle after the edge strobe of the byte's 8th sample; `cmd` holds until the next `cmd_valid`.
- `miso` changes the cycle after the shift-edge strobe.
- `start` in WAIT: state changes next cycle; `busy` high that cycle.

## Test plan
- Mode 0, reset then `cs_n` low, host sends FF FF 40 00 00 00 00 95 → one `cmd_valid`, `cmd`=48'h400000000095, `miso` all 1s.
- RX, `size`=3: host sends FF FF FE 11 22 33 44 → `buf_we` ×4, addr 0..3 with data 11,22,33,44, then one `done`.
- TX mode 3, `size`=1, buffer {A5,3C}: host clocks 3 bytes → `miso` yields FE A5 3C, `done` after 24th shift edge.
- All four CPOL/CPHA values, command 0x51 00 00 02 00 FF → identical `cmd` each.
- `cs_n` rises after 12 bits of RX data → one `abort`, no `done`, no `buf_we` for the partial byte, state IDLE; next frame decodes normally.
- `rst` asserted mid-TX → all outputs at reset values next cycle, `miso`=1.
